// File: rtl/iic_cfg_pkg.sv
// Shared definitions for the table-driven IIC configuration sequencer:
// table entry layout, op encodings and the sequencer state enumeration.
package iic_cfg_pkg;

    localparam int ENTRY_W  = 18;
    localparam int OP_LSB   = 16;
    localparam int REG_LSB  = 8;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        OP_WRITE        = 2'd0,
        OP_WRITE_VERIFY = 2'd1,
        OP_DELAY        = 2'd2,
        OP_END          = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE_WAIT = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_WR_START  = 4'd3,
        ST_WR_WAIT   = 4'd4,
        ST_RD_START  = 4'd5,
        ST_RD_WAIT   = 4'd6,
        ST_CHECK     = 4'd7,
        ST_DELAY     = 4'd8,
        ST_NEXT      = 4'd9,
        ST_FAIL      = 4'd10,
        ST_GAP       = 4'd11,
        ST_DONE      = 4'd12,
        ST_ERROR     = 4'd13
    } state_e;

    function automatic logic [ENTRY_W-1:0] make_entry(op_e op, logic [7:0] reg_addr,
                                                       logic [7:0] data);
        return {op, reg_addr, data};
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/iic_cfg_table_rom.sv
// ADV7511 HDMI transmitter setup table with a registered one-cycle read.
// Sits beside iic_cfg_sequencer and feeds its i_tbl_entry input.
module iic_cfg_table_rom
    import iic_cfg_pkg::*;
#(
    parameter int TBL_AW = 6
) (
    input  logic                i_clk,
    input  logic [TBL_AW-1:0]   i_tbl_idx,
    output logic [ENTRY_W-1:0]  o_tbl_entry
);

    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] r_entry;

    always_comb begin
        w_entry = make_entry(OP_END, 8'h00, 8'h00);
        case (int'(i_tbl_idx))
            0:  w_entry = make_entry(OP_WRITE,        8'h41, 8'h10); // power up
            1:  w_entry = make_entry(OP_DELAY,        8'h00, 8'h01);
            2:  w_entry = make_entry(OP_WRITE,        8'h98, 8'h03);
            3:  w_entry = make_entry(OP_WRITE,        8'h9A, 8'hE0);
            4:  w_entry = make_entry(OP_WRITE,        8'h9C, 8'h30);
            5:  w_entry = make_entry(OP_WRITE,        8'h9D, 8'h61);
            6:  w_entry = make_entry(OP_WRITE,        8'hA2, 8'hA4);
            7:  w_entry = make_entry(OP_WRITE,        8'hA3, 8'hA4);
            8:  w_entry = make_entry(OP_WRITE,        8'hE0, 8'hD0);
            9:  w_entry = make_entry(OP_WRITE,        8'hF9, 8'h00);
            10: w_entry = make_entry(OP_WRITE,        8'h15, 8'h00);
            11: w_entry = make_entry(OP_WRITE_VERIFY, 8'h16, 8'h30); // RGB 4:4:4 input
            12: w_entry = make_entry(OP_WRITE,        8'h18, 8'h46);
            13: w_entry = make_entry(OP_WRITE,        8'hAF, 8'h06); // HDMI mode
            14: w_entry = make_entry(OP_WRITE,        8'hD6, 8'hC0);
            default: w_entry = make_entry(OP_END, 8'h00, 8'h00);
        endcase
    end

    always_ff @(posedge i_clk) begin
        r_entry <= w_entry;
    end

    assign o_tbl_entry = r_entry;

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Table-driven IIC register configuration engine: walks the register table,
// issues byte transactions to the IIC master, retries on failure, reports status.
module iic_cfg_sequencer
    import iic_cfg_pkg::*;
#(
    parameter int TBL_AW         = 6,
    parameter int STARTUP_CYCLES = 2500000,
    parameter int DELAY_UNIT     = 25000,
    parameter int MAX_RETRY      = 3,
    parameter int RETRY_GAP      = 2500
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_restart,
    output logic [TBL_AW-1:0]   o_tbl_idx,
    input  logic [ENTRY_W-1:0]  i_tbl_entry,
    output logic                o_start,
    output logic                o_wr_rd_en,
    output logic [7:0]          o_addr,
    output logic [7:0]          o_din,
    input  logic                i_finish,
    input  logic                i_no_ack,
    input  logic                i_dout_en,
    input  logic [7:0]          i_dout,
    output logic                o_iic_main,
    output logic                o_config_ok,
    output logic                o_error,
    output logic [TBL_AW-1:0]   o_err_idx
);

    localparam int CNT_MAX = max3(STARTUP_CYCLES, 255 * DELAY_UNIT, RETRY_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TBL_AW-1:0] LAST_IDX = '1;

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_boot;
    logic [RTY_W-1:0]   r_retry;
    logic [TBL_AW-1:0]  r_idx;
    op_e                r_op;
    logic [7:0]         r_reg;
    logic [7:0]         r_data;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;
    logic               r_rd_nack;
    logic               r_ok;
    logic               r_error;
    logic [TBL_AW-1:0]  r_err_idx;

    op_e                w_op;
    logic [7:0]         w_tbl_data;
    logic               w_retry_left;
    logic               w_start;
    logic               w_rd;
    logic               w_main;

    assign w_op         = op_e'(i_tbl_entry[OP_LSB +: 2]);
    assign w_tbl_data   = i_tbl_entry[DATA_LSB +: 8];
    assign w_retry_left = (r_retry < RTY_W'(MAX_RETRY));

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_rd    = 1'b0;
        w_main  = 1'b1;
        case (r_state)
            ST_IDLE_WAIT: begin
                w_main = 1'b0;
                // r_boot marks that the startup count has been loaded
                if (r_boot && (r_cnt == '0)) w_next = ST_FETCH;
            end
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                case (w_op)
                    OP_WRITE, OP_WRITE_VERIFY: w_next = ST_WR_START;
                    OP_DELAY:                  w_next = ST_DELAY;
                    default:                   w_next = ST_DONE;
                endcase
            end
            ST_WR_START: begin
                w_start = 1'b1;
                w_next  = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (i_finish) begin
                    if (i_no_ack)                     w_next = ST_FAIL;
                    else if (r_op == OP_WRITE_VERIFY) w_next = ST_RD_START;
                    else                              w_next = ST_NEXT;
                end
            end
            ST_RD_START: begin
                w_start = 1'b1;
                w_rd    = 1'b1;
                w_next  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_rd = 1'b1;
                if (i_finish) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (r_rd_valid && !r_rd_nack && (r_rd_data == r_data)) w_next = ST_NEXT;
                else                                                   w_next = ST_FAIL;
            end
            ST_DELAY: begin
                if (r_cnt == '0) w_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_idx == LAST_IDX) w_next = ST_DONE;
                else                   w_next = ST_FETCH;
            end
            ST_FAIL: begin
                if (w_retry_left) w_next = ST_GAP;
                else              w_next = ST_ERROR;
            end
            ST_GAP: begin
                if (r_cnt == '0) w_next = ST_WR_START;
            end
            ST_DONE, ST_ERROR: begin
                w_main = 1'b0;
                if (i_restart) w_next = ST_FETCH;
            end
            default: w_next = ST_IDLE_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE_WAIT;
            r_cnt      <= '0;
            r_boot     <= 1'b0;
            r_retry    <= '0;
            r_idx      <= '0;
            r_op       <= OP_WRITE;
            r_reg      <= '0;
            r_data     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_nack  <= 1'b0;
            r_ok       <= 1'b0;
            r_error    <= 1'b0;
            r_err_idx  <= '0;
        end else begin
            r_state <= w_next;
            // shared wait counter saturates at zero; loads below override
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            case (r_state)
                ST_IDLE_WAIT: begin
                    if (!r_boot) begin
                        r_boot <= 1'b1;
                        r_cnt  <= CNT_W'(STARTUP_CYCLES);
                    end
                end
                ST_DECODE: begin
                    r_op   <= w_op;
                    r_reg  <= i_tbl_entry[REG_LSB +: 8];
                    r_data <= w_tbl_data;
                    if (w_op == OP_DELAY) r_cnt <= CNT_W'(w_tbl_data) * CNT_W'(DELAY_UNIT);
                    if (w_op == OP_END)   r_ok  <= 1'b1;
                end
                ST_RD_START: begin
                    r_rd_valid <= 1'b0;
                    r_rd_nack  <= 1'b0;
                end
                ST_RD_WAIT: begin
                    if (i_dout_en) begin
                        r_rd_data  <= i_dout;
                        r_rd_valid <= 1'b1;
                    end
                    if (i_finish) r_rd_nack <= i_no_ack;
                end
                ST_NEXT: begin
                    r_retry <= '0;
                    if (r_idx == LAST_IDX) r_ok  <= 1'b1;
                    else                   r_idx <= r_idx + TBL_AW'(1);
                end
                ST_FAIL: begin
                    if (w_retry_left) begin
                        r_retry <= r_retry + RTY_W'(1);
                        r_cnt   <= CNT_W'(RETRY_GAP);
                    end else begin
                        r_error   <= 1'b1;
                        r_err_idx <= r_idx;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (i_restart) begin
                        r_ok      <= 1'b0;
                        r_error   <= 1'b0;
                        r_err_idx <= '0;
                        r_idx     <= '0;
                        r_retry   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // address/data come from registers latched in DECODE, so they stay put
    // for the whole transaction
    assign o_tbl_idx   = r_idx;
    assign o_start     = w_start;
    assign o_wr_rd_en  = w_rd;
    assign o_addr      = r_reg;
    assign o_din       = r_data;
    assign o_iic_main  = w_main;
    assign o_config_ok = r_ok;
    assign o_error     = r_error;
    assign o_err_idx   = r_err_idx;

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// Directed bench for iic_cfg_sequencer: table model, IIC master model that
// finishes 8 cycles after each start, and a linear sequence of scenarios.
module tb_iic_cfg_sequencer;
    import iic_cfg_pkg::*;

    localparam int AW = 3;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_restart = 1'b0;
    logic [AW-1:0]     o_tbl_idx;
    logic [ENTRY_W-1:0] i_tbl_entry;
    logic              o_start;
    logic              o_wr_rd_en;
    logic [7:0]        o_addr;
    logic [7:0]        o_din;
    logic              i_finish = 1'b0;
    logic              i_no_ack = 1'b0;
    logic              i_dout_en = 1'b0;
    logic [7:0]        i_dout = 8'h00;
    logic              o_iic_main;
    logic              o_config_ok;
    logic              o_error;
    logic [AW-1:0]     o_err_idx;

    iic_cfg_sequencer #(
        .TBL_AW(AW), .STARTUP_CYCLES(20), .DELAY_UNIT(10), .MAX_RETRY(3), .RETRY_GAP(5)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_restart(i_restart), .o_tbl_idx(o_tbl_idx),
        .i_tbl_entry(i_tbl_entry), .o_start(o_start), .o_wr_rd_en(o_wr_rd_en),
        .o_addr(o_addr), .o_din(o_din), .i_finish(i_finish), .i_no_ack(i_no_ack),
        .i_dout_en(i_dout_en), .i_dout(i_dout), .o_iic_main(o_iic_main),
        .o_config_ok(o_config_ok), .o_error(o_error), .o_err_idx(o_err_idx)
    );

    always #5 i_clk = ~i_clk;

    // registered table model
    logic [ENTRY_W-1:0] tbl [8];
    always @(posedge i_clk) i_tbl_entry <= tbl[o_tbl_idx];

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] nack_addr = 8'h00;
    int         nack_left = 0;
    logic [7:0] rd_value  = 8'h00;

    logic [7:0] st_addr[$];
    logic [7:0] st_din[$];
    logic       st_rd[$];
    int         st_cyc[$];
    int         fin_cyc[$];
    int         overlap_err = 0;
    int         hold_err = 0;
    int         rel_cyc = 0;

    // IIC master model
    initial begin : iic_model
        logic       busy;
        int         cnt;
        logic [7:0] a;
        logic [7:0] d;
        logic       rd;
        busy = 1'b0; cnt = 0; a = 8'h00; d = 8'h00; rd = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            i_finish = 1'b0; i_no_ack = 1'b0; i_dout_en = 1'b0;
            if (i_rst) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (o_addr !== a || o_din !== d || o_wr_rd_en !== rd) hold_err++;
                    cnt--;
                    if (cnt == 0) begin
                        busy = 1'b0;
                        i_finish = 1'b1;
                        fin_cyc.push_back(cyc);
                        if (rd) begin
                            i_dout_en = 1'b1;
                            i_dout = rd_value;
                        end else if (a == nack_addr && nack_left != 0) begin
                            i_no_ack = 1'b1;
                            if (nack_left > 0) nack_left--;
                        end
                    end
                end
                if (o_start) begin
                    if (busy) overlap_err++;
                    busy = 1'b1; cnt = 8; a = o_addr; d = o_din; rd = o_wr_rd_en;
                    st_addr.push_back(o_addr);
                    st_din.push_back(o_din);
                    st_rd.push_back(o_wr_rd_en);
                    st_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 8; i++) tbl[i] = make_entry(OP_END, 8'h00, 8'h00);
    endtask

    task automatic do_reset(input string tag);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk({tag, "_rst_outputs"},
            {5'b0, o_start, o_wr_rd_en, o_iic_main, o_config_ok, o_error,
             o_addr, o_din, o_tbl_idx, o_err_idx}, 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        st_addr.delete(); st_din.delete(); st_rd.delete(); st_cyc.delete(); fin_cyc.delete();
        overlap_err = 0; hold_err = 0;
        i_rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(o_config_ok || o_error) && n < 4000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({tag, "_timeout"}, (n >= 4000), 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_starts(input string tag, input int cnt);
        int n;
        n = 0;
        while (st_cyc.size() < cnt && n < 4000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({tag, "_start_timeout"}, (n >= 4000), 1'b0);
    endtask

    int p_cyc;
    int n98;

    initial begin
        clear_tbl();

        // basic two-write table
        tbl[0] = make_entry(OP_WRITE, 8'h41, 8'h10);
        tbl[1] = make_entry(OP_WRITE, 8'h98, 8'h03);
        do_reset("basic");
        wait_end("basic");
        chk("basic_nstarts", st_cyc.size(), 2);
        chk("basic_s0", {st_rd[0], st_addr[0], st_din[0]}, {1'b0, 8'h41, 8'h10});
        chk("basic_s1", {st_rd[1], st_addr[1], st_din[1]}, {1'b0, 8'h98, 8'h03});
        chk("basic_status", {o_config_ok, o_error, o_iic_main}, 3'b100);
        chk("basic_latency", (st_cyc[0] - rel_cyc) >= 21, 1'b1);
        chk("basic_end_idx", o_tbl_idx, 3'd2);
        chk("basic_overlap", overlap_err, 0);
        chk("basic_hold", hold_err, 0);

        // NACK on first two attempts of entry 0
        nack_addr = 8'h41; nack_left = 2;
        do_reset("retry");
        wait_end("retry");
        chk("retry_nstarts", st_cyc.size(), 4);
        chk("retry_addrs", {st_addr[0], st_addr[1], st_addr[2], st_addr[3]}, 32'h41414198);
        chk("retry_gap0", (st_cyc[1] - fin_cyc[0]) >= 5, 1'b1);
        chk("retry_gap1", (st_cyc[2] - fin_cyc[1]) >= 5, 1'b1);
        chk("retry_status", {o_config_ok, o_error}, 2'b10);

        // NACK forever at entry 1, then restart
        nack_addr = 8'h98; nack_left = -1;
        do_reset("err");
        wait_end("err");
        n98 = 0;
        foreach (st_addr[i]) if (st_addr[i] == 8'h98) n98++;
        chk("err_nstarts", st_cyc.size(), 5);
        chk("err_n98", n98, 4);
        chk("err_status", {o_config_ok, o_error, o_iic_main, o_err_idx}, {3'b010, 3'd1});
        nack_left = 0;
        st_addr.delete(); st_din.delete(); st_rd.delete(); st_cyc.delete(); fin_cyc.delete();
        @(posedge i_clk); #1;
        i_restart = 1'b1;
        p_cyc = cyc;
        @(posedge i_clk); #1;
        i_restart = 1'b0;
        chk("restart_cleared", {o_error, o_config_ok, o_iic_main, o_tbl_idx, o_err_idx},
            {3'b001, 3'd0, 3'd0});
        wait_end("restart");
        chk("restart_nostartup", (st_cyc[0] - p_cyc) <= 5, 1'b1);
        chk("restart_nstarts", st_cyc.size(), 2);
        chk("restart_status", {o_config_ok, o_error}, 2'b10);

        // verify mismatch: every attempt is write + read, all fail
        clear_tbl();
        tbl[0] = make_entry(OP_WRITE_VERIFY, 8'h16, 8'h34);
        rd_value = 8'h12;
        do_reset("vbad");
        wait_end("vbad");
        chk("vbad_nstarts", st_cyc.size(), 8);
        chk("vbad_rd_pattern", {st_rd[0], st_rd[1], st_rd[2], st_rd[3]}, 4'b0101);
        chk("vbad_rd_addr", st_addr[1], 8'h16);
        chk("vbad_status", {o_config_ok, o_error, o_err_idx}, {2'b01, 3'd0});

        // verify match
        rd_value = 8'h34;
        do_reset("vok");
        wait_end("vok");
        chk("vok_nstarts", st_cyc.size(), 2);
        chk("vok_wr", {st_rd[0], st_addr[0], st_din[0]}, {1'b0, 8'h16, 8'h34});
        chk("vok_rd", {st_rd[1], st_addr[1]}, {1'b1, 8'h16});
        chk("vok_status", {o_config_ok, o_error, o_tbl_idx}, {2'b10, 3'd1});

        // timed delay between writes
        clear_tbl();
        tbl[0] = make_entry(OP_WRITE, 8'h41, 8'h10);
        tbl[1] = make_entry(OP_DELAY, 8'h00, 8'h03);
        tbl[2] = make_entry(OP_WRITE, 8'h98, 8'h03);
        do_reset("dly");
        wait_end("dly");
        chk("dly_nstarts", st_cyc.size(), 2);
        chk("dly_gap", (st_cyc[1] - fin_cyc[0]) >= 30, 1'b1);
        chk("dly_s1", st_addr[1], 8'h98);
        chk("dly_status", o_config_ok, 1'b1);

        // full table with no END entry: finishes at the last index
        for (int i = 0; i < 8; i++) tbl[i] = make_entry(OP_WRITE, 8'h60 + 8'(i), 8'(i));
        do_reset("full");
        wait_end("full");
        chk("full_nstarts", st_cyc.size(), 8);
        chk("full_last", {st_addr[7], st_din[7]}, {8'h67, 8'h07});
        chk("full_status", {o_config_ok, o_error, o_tbl_idx}, {2'b10, 3'd7});

        // reset while a write is outstanding
        clear_tbl();
        tbl[0] = make_entry(OP_WRITE, 8'h41, 8'h10);
        tbl[1] = make_entry(OP_WRITE, 8'h98, 8'h03);
        do_reset("mid_pre");
        wait_starts("mid", 1);
        repeat (3) @(posedge i_clk);
        do_reset("mid");
        wait_end("mid");
        chk("mid_nstarts", st_cyc.size(), 2);
        chk("mid_latency", (st_cyc[0] - rel_cyc) >= 21, 1'b1);
        chk("mid_status", {o_config_ok, o_error, o_iic_main}, 3'b100);
        chk("mid_overlap_hold", overlap_err + hold_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
